// File: rtl/pq_pkg.sv
// rtl/pq_pkg.sv - shared entry-field widths for the register-array PQ and its front-end
package pq_pkg;
   parameter int KEY_WIDTH = 8;
   parameter int VAL_WIDTH = 8;
endpackage

// File: rtl/pq_req_ctrl.sv
// rtl/pq_req_ctrl.sv - request front-end that buffers enqueues and sequences PQ enq/deq strobes
//
// Purpose: accepts {key,val} enqueue words into a small FIFO and dequeue requests,
// drives the PQ enq/deq strobes according to the PQ busy handshake, and returns
// dequeued entries on a registered output slot.
//
// Optional feature: define PQ_REQ_WDOG_EN to enable the ENQ_WAIT watchdog
// (abort after WDOG_CYCLES without pq_busy, discard the FIFO head, set sticky err).
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_kv/in_valid/in_ready  enqueue word channel into the FIFO
//   deq_valid/deq_ready      dequeue request; deq_ready pulses with the PQ deq strobe
//   out_kv/out_valid/out_ready  registered dequeued entry
//   pq_kvi/pq_enq/pq_deq     to the PQ (pq_kvi is always the FIFO head)
//   pq_busy/pq_full/pq_empty/pq_kvo  from the PQ
//   fifo_cnt                 FIFO occupancy
//   err                      sticky watchdog abort flag (constant 0 without the watchdog)
module pq_req_ctrl #(
   parameter int KEY_WIDTH   = pq_pkg::KEY_WIDTH,
   parameter int VAL_WIDTH   = pq_pkg::VAL_WIDTH,
   parameter int FIFO_DEPTH  = 4,
   parameter int WDOG_CYCLES = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0]    in_kv,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              deq_valid,
   output logic                              deq_ready,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0]    out_kv,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [KEY_WIDTH+VAL_WIDTH-1:0]    pq_kvi,
   output logic                              pq_enq,
   output logic                              pq_deq,
   input  logic                              pq_busy,
   input  logic                              pq_full,
   input  logic                              pq_empty,
   input  logic [KEY_WIDTH+VAL_WIDTH-1:0]    pq_kvo,
   output logic [$clog2(FIFO_DEPTH):0]       fifo_cnt,
   output logic                              err
);

   localparam int KV_W  = KEY_WIDTH + VAL_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ENQ_WAIT,
      S_ENQ_HOLD,
      S_GAP
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [KV_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_cnt;
   logic [KV_W-1:0]   r_out_kv;
   logic              r_out_valid;

   logic              w_push;
   logic              w_pop;
   logic              w_enq;
   logic              w_deq;
   logic              w_capture;
   logic              w_deq_ready;
   logic              w_fifo_nempty;
   logic              w_slot_free;

`ifdef PQ_REQ_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] r_wdog;
   logic              r_err;
   logic              w_wdog_expired;
   assign w_wdog_expired = (r_wdog == WDOG_W'(WDOG_CYCLES));
`endif

   // ---------------- enqueue FIFO ----------------
   assign in_ready      = (r_cnt != CNT_W'(FIFO_DEPTH));
   assign w_push        = in_valid && in_ready;
   assign w_fifo_nempty = (r_cnt != '0);
   assign pq_kvi        = r_mem[r_rd_ptr];
   assign fifo_cnt      = r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage needs no reset: the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_kv;
   end

   // ---------------- request sequencer ----------------
   // The output slot can take a new entry if empty or being drained this cycle.
   assign w_slot_free = !r_out_valid || out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_enq       = 1'b0;
      w_deq       = 1'b0;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_deq_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!pq_busy) begin
               if (deq_valid && w_fifo_nempty && !pq_empty && w_slot_free) begin
                  // Combined replace: the PQ accepts this even when full.
                  w_enq       = 1'b1;
                  w_deq       = 1'b1;
                  w_capture   = 1'b1;
                  w_deq_ready = 1'b1;
                  w_pop       = 1'b1;
                  w_state_nxt = S_GAP;
               end else if (deq_valid && !pq_empty && w_slot_free) begin
                  w_deq       = 1'b1;
                  w_capture   = 1'b1;
                  w_deq_ready = 1'b1;
                  w_state_nxt = S_GAP;
               end else if (w_fifo_nempty && !pq_full) begin
                  w_enq       = 1'b1;
                  w_state_nxt = S_ENQ_WAIT;
               end
            end
         end
         S_ENQ_WAIT: begin
            // Head stays in place so pq_kvi is stable until the PQ takes it.
            w_enq = 1'b1;
            if (pq_busy) begin
               w_state_nxt = S_ENQ_HOLD;
            end
`ifdef PQ_REQ_WDOG_EN
            else if (w_wdog_expired) begin
               w_enq       = 1'b0;
               w_pop       = 1'b1;
               w_state_nxt = S_GAP;
            end
`endif
         end
         S_ENQ_HOLD: begin
            w_enq       = 1'b1;
            w_pop       = 1'b1;
            w_state_nxt = S_GAP;
         end
         S_GAP: begin
            // One cycle with every strobe low so the PQ sees a clean edge.
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign pq_enq    = w_enq;
   assign pq_deq    = w_deq;
   assign deq_ready = w_deq_ready;

   // ---------------- output slot ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_kv    <= '0;
         r_out_valid <= 1'b0;
      end else if (w_capture) begin
         r_out_kv    <= pq_kvo;
         r_out_valid <= 1'b1;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_kv    = r_out_kv;
   assign out_valid = r_out_valid;

   // ---------------- watchdog ----------------
`ifdef PQ_REQ_WDOG_EN
   // Counts ENQ_WAIT cycles without busy; cleared whenever the FSM leaves ENQ_WAIT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (r_state == S_ENQ_WAIT && !pq_busy && !w_wdog_expired)
            r_wdog <= r_wdog + WDOG_W'(1);
         else
            r_wdog <= '0;
         if (r_state == S_ENQ_WAIT && !pq_busy && w_wdog_expired)
            r_err <= 1'b1;
      end
   end
   assign err = r_err;
`else
   // Watchdog compiled out: err is constant 0 and WDOG_CYCLES has no effect.
   assign err = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_pq_req_ctrl.sv
// tb/tb_pq_req_ctrl.sv - scoreboard bench for pq_req_ctrl with a behavioural min-key PQ
`timescale 1ns/1ps
module tb_pq_req_ctrl;
   localparam int KW = 8, VW = 8, KVW = 16, FD = 4, WD = 16, PQ_CAP = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [KVW-1:0] in_kv;
   logic           in_valid;
   logic           in_ready;
   logic           deq_valid;
   logic           deq_ready;
   logic [KVW-1:0] out_kv;
   logic           out_valid;
   logic           out_ready;
   logic [KVW-1:0] pq_kvi;
   logic           pq_enq;
   logic           pq_deq;
   logic           pq_busy;
   logic           pq_full;
   logic           pq_empty;
   logic [KVW-1:0] pq_kvo;
   logic [2:0]     fifo_cnt;
   logic           err;

   always #5 clk = ~clk;

   pq_req_ctrl #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .FIFO_DEPTH(FD), .WDOG_CYCLES(WD)) dut (
      .clk(clk), .rst(rst), .in_kv(in_kv), .in_valid(in_valid), .in_ready(in_ready),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .out_kv(out_kv), .out_valid(out_valid),
      .out_ready(out_ready), .pq_kvi(pq_kvi), .pq_enq(pq_enq), .pq_deq(pq_deq),
      .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty), .pq_kvo(pq_kvo),
      .fifo_cnt(fifo_cnt), .err(err));

   int n_checks = 0;
   int n_errors = 0;

   logic [KVW-1:0] exp_ins[$];
   logic [KVW-1:0] exp_out[$];
   logic [KVW-1:0] pq_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_errors++;
      $display("FAIL %s: event did not occur within its bound", name);
   endtask

   task automatic pq_insert(input logic [KVW-1:0] kv);
      int idx = 0;
      while (idx < pq_q.size() && pq_q[idx][15:8] <= kv[15:8]) idx++;
      pq_q.insert(idx, kv);
      if (exp_ins.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL pq_insert_unexpected: got 0x%0h, required no insertion", kv);
      end else begin
         check("pq_insert_order", kv, exp_ins.pop_front());
      end
   endtask

   // ---------- behavioural PQ: inputs sampled mid-cycle, state updated on the edge ----------
   logic           s_enq, s_deq, s_busy;
   logic [KVW-1:0] s_kvi;
   logic           m_prev_enq;
   logic           m_stuck;
   logic [KVW-1:0] m_kv;
   int             ph;
   int             combo_cnt;
   int             deq_acc;

   always @(negedge clk) begin
      s_enq  <= pq_enq;
      s_deq  <= pq_deq;
      s_busy <= pq_busy;
      s_kvi  <= pq_kvi;
      if (deq_ready) deq_acc <= deq_acc + 1;
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pq_q.delete();
         ph         <= 0;
         pq_busy    <= 1'b0;
         m_prev_enq <= 1'b0;
         pq_kvo     <= '0;
         pq_empty   <= 1'b1;
         pq_full    <= 1'b0;
      end else begin
         m_prev_enq <= s_enq;
         if ((s_enq && !m_prev_enq) || s_deq) check("strobe_while_busy", s_busy, 0);
         case (ph)
            0: begin
               if (s_enq && s_deq && !m_prev_enq) begin
                  combo_cnt <= combo_cnt + 1;
                  check("combo_nonempty", pq_q.size() != 0, 1);
                  if (pq_q.size() != 0) void'(pq_q.pop_front());
                  pq_insert(s_kvi);
               end else if (s_deq) begin
                  check("deq_nonempty", pq_q.size() != 0, 1);
                  if (pq_q.size() != 0) void'(pq_q.pop_front());
               end else if (s_enq && !m_prev_enq && !m_stuck) begin
                  m_kv <= s_kvi;
                  ph   <= 1;
               end
            end
            1: ph <= 2;
            2: begin pq_busy <= 1'b1; ph <= 3; end
            3: begin
               check("enq_at_busy", s_enq, 1);
               pq_busy <= 1'b0;
               pq_insert(m_kv);
               ph <= 4;
            end
            4: begin check("enq_hold_plus1", s_enq, 1); ph <= 5; end
            5: begin check("enq_gap", {s_enq, s_deq}, 0); ph <= 0; end
            default: ph <= 0;
         endcase
         pq_kvo   <= (pq_q.size() != 0) ? pq_q[0] : '0;
         pq_empty <= (pq_q.size() == 0);
         pq_full  <= (pq_q.size() >= PQ_CAP);
      end
   end

   // ---------- output monitor ----------
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_out.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_unexpected: got 0x%0h, required no output", out_kv);
         end else begin
            check("out_kv", out_kv, exp_out.pop_front());
         end
      end
   end

   // ---------- stimulus ----------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [KVW-1:0] kv);
      logic ok = 1'b0;
      in_kv    = kv;
      in_valid = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) fail("push_timeout");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_deq_accept();
      logic ok = 1'b0;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = deq_ready;
      end
      if (!ok) fail("deq_timeout");
      @(posedge clk);
      #1;
      deq_valid = 1'b0;
   endtask

   task automatic deq();
      deq_valid = 1'b1;
      wait_deq_accept();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int d0, c0;
      logic [KVW-1:0] burst [5];
      burst = '{16'h0B0B, 16'h0909, 16'h0C0C, 16'h0A0A, 16'h0101};
      combo_cnt = 0;
      deq_acc   = 0;
      m_stuck   = 1'b0;
      in_kv     = '0;
      in_valid  = 1'b0;
      deq_valid = 1'b0;
      out_ready = 1'b1;
      rst       = 1'b1;
      #2 rst    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pq_enq", pq_enq, 0);
      check("rst_pq_deq", pq_deq, 0);
      check("rst_fifo_cnt", fifo_cnt, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_kv", out_kv, 0);
      check("rst_err", err, 0);
      check("rst_deq_ready", deq_ready, 0);
      rst = 1'b1;
      cycles(2);
      check("in_ready_after_release", in_ready, 1);

      // single enqueue, then read it back
      exp_ins.push_back(16'h080E);
      push(16'h080E);
      cycles(10);
      check("single_fifo_cnt", fifo_cnt, 0);
      exp_out.push_back(16'h080E);
      deq();
      cycles(4);

      // burst of five through a four-deep FIFO
      foreach (burst[i]) exp_ins.push_back(burst[i]);
      for (int i = 0; i < 4; i++) push(burst[i]);
      check("burst_in_ready_full", in_ready, 0);
      check("burst_fifo_cnt_full", fifo_cnt, 4);
      push(burst[4]);
      cycles(60);
      check("burst_fifo_drained", fifo_cnt, 0);
      exp_out.push_back(16'h0101);
      exp_out.push_back(16'h0909);
      exp_out.push_back(16'h0A0A);
      exp_out.push_back(16'h0B0B);
      exp_out.push_back(16'h0C0C);
      repeat (5) deq();
      cycles(4);

      // combined enqueue+dequeue
      exp_ins.push_back(16'h0B0B);
      exp_ins.push_back(16'h0909);
      exp_ins.push_back(16'h0C0C);
      push(16'h0B0B);
      push(16'h0909);
      push(16'h0C0C);
      cycles(30);
      c0 = combo_cnt;
      d0 = deq_acc;
      exp_ins.push_back(16'h0D0D);
      exp_out.push_back(16'h0909);
      push(16'h0D0D);
      deq();
      cycles(10);
      check("combo_single_cycle", combo_cnt - c0, 1);
      check("combo_deq_ready_once", deq_acc - d0, 1);
      exp_out.push_back(16'h0B0B);
      exp_out.push_back(16'h0C0C);
      exp_out.push_back(16'h0D0D);
      repeat (3) deq();
      cycles(4);

      // dequeue stalls while everything is empty
      d0 = deq_acc;
      deq_valid = 1'b1;
      cycles(8);
      check("deq_stall_empty", deq_acc - d0, 0);
      exp_ins.push_back(16'h0101);
      exp_out.push_back(16'h0101);
      push(16'h0101);
      wait_deq_accept();
      cycles(4);

      // output backpressure blocks the next dequeue
      out_ready = 1'b0;
      exp_ins.push_back(16'h0303);
      exp_ins.push_back(16'h0404);
      push(16'h0303);
      push(16'h0404);
      cycles(20);
      exp_out.push_back(16'h0303);
      exp_out.push_back(16'h0404);
      deq();
      d0 = deq_acc;
      deq_valid = 1'b1;
      cycles(10);
      check("deq_blocked_by_out", deq_acc - d0, 0);
      check("out_held_kv", out_kv, 16'h0303);
      out_ready = 1'b1;
      wait_deq_accept();
      cycles(4);

      // leave an entry in the output slot, then stall an enqueue with busy stuck low
      out_ready = 1'b0;
      exp_ins.push_back(16'h0606);
      push(16'h0606);
      cycles(20);
      deq();
      cycles(2);
      check("pre_reset_out_valid", out_valid, 1);
      check("pre_reset_out_kv", out_kv, 16'h0606);
      m_stuck = 1'b1;
      push(16'h0505);
`ifdef PQ_REQ_WDOG_EN
      cycles(8);
      check("wdog_enq_before_expiry", pq_enq, 1);
      check("wdog_err_before_expiry", err, 0);
      cycles(30);
      check("wdog_enq_dropped", pq_enq, 0);
      check("wdog_err_set", err, 1);
      check("wdog_head_discarded", fifo_cnt, 0);
`else
      cycles(100);
      check("no_wdog_enq_held", pq_enq, 1);
      check("no_wdog_err", err, 0);
      check("no_wdog_fifo_cnt", fifo_cnt, 1);
`endif
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_rst_pq_enq", pq_enq, 0);
      check("async_rst_fifo_cnt", fifo_cnt, 0);
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_err", err, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      m_stuck = 1'b0;
      cycles(2);
      check("in_ready_after_reset", in_ready, 1);

      check("exp_ins_drained", exp_ins.size(), 0);
      check("exp_out_drained", exp_out.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
